demux1_4_4b_buf: RTL and testbench
==================================

// Module: demux1_4_4b_buf
// PURPOSE
//  Four-way buffered demultiplexer: the distribution counterpart of the quad
//  4-1 mux. Accepts one N-bit stream on a valid/ready handshake and steers each
//  word to one of four output channels (A..D). Each channel has its own
//  one-entry holding register with valid/ready handshake. The channel is chosen
//  by S (direct mode) or by an internal round-robin pointer (RR mode). Used
//  wherever a single producer feeds four consumers, such as per-lane data fanout.
// PARAMETERS
//  N  4  data width of In and of each OutA..OutD
// PORTS
//  clk      in   1  system clock; all state changes on the rising edge
//  rst      in   1  synchronous reset, active-high
//  In       in   N  input data word
//  InValid  in   1  In holds a valid word
//  InReady  out  1  block can accept In this cycle (combinational)
//  S        in   2  channel select in direct mode: 0=A 1=B 2=C 3=D
//  Mode     in   1  0=direct (use S), 1=round-robin (ignore S)
//  OutA..D  out  N  channel holding-register data, one port per channel
//  ValidA..D out 1  channel register holds a word
//  ReadyA..D in  1  consumer takes the word this cycle
//  Ptr      out  2  current round-robin pointer (observability)
// BEHAVIOUR
//  - Reset (rst=1 at edge): ValidA..D=0, OutA..D=0, Ptr=0. Buffered words are
//    discarded, including when reset arrives mid-stream. InReady stays 0 while
//    rst=1.
//  - sel = Mode ? Ptr : S (combinational).
//  - Channel X can load when it is empty or its word drains this cycle:
//    canX = !ValidX | ReadyX.
//  - InReady = !rst & can[sel]. Accept = InValid & InReady.
//  - On Accept: Out[sel] <= In and Valid[sel] <= 1 at the next edge, so latency
//    is 1 cycle from accept to ValidX.
//  - Channel drain: ValidX & ReadyX with no load into X gives ValidX <= 0 and
//    OutX holds its value. ReadyX while ValidX=0 has no effect.
//  - Simultaneous drain and load on the same channel: the new word replaces the
//    old one and ValidX stays 1, so one word per cycle passes through
//    back-to-back.
//  - The other three channels are unaffected by an accept. All four channels
//    may drain in the same cycle.
//  - A full channel with ReadyX=0 stalls only transfers aimed at it. The
//    producer may change S or In while stalled. No word is committed until
//    Accept.
//  - Round-robin: Ptr <= Ptr+1 (mod 4, 3 wraps to 0) on each Accept while
//    Mode=1. Ptr is unchanged otherwise and in direct mode. Ptr is not reset by
//    Mode changes, so RR mode resumes where it left off.
//  - Mode switches take effect combinationally in the same cycle.
//  - No word is ever dropped or duplicated. Each accepted word appears exactly
//    once on exactly one channel, in acceptance order per channel.
// TESTING
//  1 Reset: hold rst 2 cycles mid-traffic -> all Valid=0, Out=0, Ptr=0,
//    InReady=0 during rst.
//  2 Direct mode, all Ready=1, S=2, In=4'hA, InValid=1 -> next cycle OutC=A,
//    ValidC=1, other channels unchanged.
//  3 Backpressure: ReadyB=0, load B with 4'h3, then S=1 In=4'h5 -> InReady=0,
//    OutB stays 3. S=0 same cycle -> accepted into A.
//  4 Pass-through: ValidD=1, ReadyD=1, S=3, In=4'h7 every cycle -> InReady=1
//    each cycle, OutD updates each cycle, ValidD never drops.
//  5 Round-robin: Mode=1, 5 accepts of 1,2,3,4,5 -> A=1 B=2 C=3 D=4, then A=5.
//    Ptr 0,1,2,3,0,1. A stall does not advance Ptr.
//  6 Random S/Mode/Ready/InValid for 10k cycles against a scoreboard -> no loss,
//    no duplication, per-channel order preserved.

Source files
------------

// File: rtl/demux1_4_4b_buf.sv
// Four-way buffered demultiplexer: one valid/ready input stream steered to four
// one-entry holding registers, selected by S (direct) or a round-robin pointer.
module demux1_4_4b_buf #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] In,
    input  logic         InValid,
    output logic         InReady,
    input  logic [1:0]   S,
    input  logic         Mode,
    output logic [N-1:0] OutA,
    output logic [N-1:0] OutB,
    output logic [N-1:0] OutC,
    output logic [N-1:0] OutD,
    output logic         ValidA,
    output logic         ValidB,
    output logic         ValidC,
    output logic         ValidD,
    input  logic         ReadyA,
    input  logic         ReadyB,
    input  logic         ReadyC,
    input  logic         ReadyD,
    output logic [1:0]   Ptr
);

    logic [N-1:0] data_q [4];
    logic [3:0]   valid_q;
    logic [1:0]   ptr_q;
    logic [3:0]   rdy;
    logic [3:0]   can;
    logic [1:0]   sel;
    logic         accept;

    assign rdy    = {ReadyD, ReadyC, ReadyB, ReadyA};
    assign sel    = Mode ? ptr_q : S;
    // A channel can take a new word if empty or its current word leaves this cycle
    assign can    = ~valid_q | rdy;
    assign InReady = !rst && can[sel];
    assign accept = InValid && InReady;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            ptr_q   <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (accept && (sel == i[1:0])) begin
                    data_q[i]  <= In;
                    valid_q[i] <= 1'b1;
                end else if (rdy[i]) begin
                    valid_q[i] <= 1'b0;
                end
            end
            if (accept && Mode) begin
                ptr_q <= ptr_q + 2'd1;
            end
        end
    end

    assign OutA   = data_q[0];
    assign OutB   = data_q[1];
    assign OutC   = data_q[2];
    assign OutD   = data_q[3];
    assign ValidA = valid_q[0];
    assign ValidB = valid_q[1];
    assign ValidC = valid_q[2];
    assign ValidD = valid_q[3];
    assign Ptr    = ptr_q;

endmodule

// File: tb/tb_demux1_4_4b_buf.sv
// Bench for demux1_4_4b_buf: directed scenarios then random traffic, checked
// against a per-channel queue scoreboard and an abstract buffer model.
module tb_demux1_4_4b_buf;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] In;
    logic       InValid;
    logic       InReady;
    logic [1:0] S;
    logic       Mode;
    logic [3:0] OutA, OutB, OutC, OutD;
    logic       ValidA, ValidB, ValidC, ValidD;
    logic       ReadyA, ReadyB, ReadyC, ReadyD;
    logic [1:0] Ptr;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] outs [4];
    logic [3:0] vals;

    // Abstract model: what each channel should hold, plus undelivered words
    int m_data [4];
    bit m_valid [4];
    int m_ptr;
    int q [4][$];

    demux1_4_4b_buf #(.N(4)) dut (
        .clk(clk), .rst(rst), .In(In), .InValid(InValid), .InReady(InReady),
        .S(S), .Mode(Mode),
        .OutA(OutA), .OutB(OutB), .OutC(OutC), .OutD(OutD),
        .ValidA(ValidA), .ValidB(ValidB), .ValidC(ValidC), .ValidD(ValidD),
        .ReadyA(ReadyA), .ReadyB(ReadyB), .ReadyC(ReadyC), .ReadyD(ReadyD),
        .Ptr(Ptr)
    );

    always #5 clk = ~clk;

    assign outs[0] = OutA;
    assign outs[1] = OutB;
    assign outs[2] = OutC;
    assign outs[3] = OutD;
    assign vals    = {ValidD, ValidC, ValidB, ValidA};

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive, check combinational ready and drains, then registers
    task automatic cyc(input bit r, input bit iv, input int din, input int s,
                       input bit m, input bit [3:0] rd);
        int  sel;
        bit  exp_rdy;
        bit  acc;
        int  w;
        rst = r; InValid = iv; In = din[3:0]; S = s[1:0]; Mode = m;
        {ReadyD, ReadyC, ReadyB, ReadyA} = rd;
        #1;
        sel = m ? m_ptr : s;
        exp_rdy = !r && (!m_valid[sel] || rd[sel]);
        check("inready", int'(InReady), int'(exp_rdy));
        acc = iv && exp_rdy;
        if (!r) begin
            for (int ch = 0; ch < 4; ch++) begin
                if (vals[ch] && rd[ch]) begin
                    if (q[ch].size() == 0) begin
                        check("spurious_word", 1, 0);
                    end else begin
                        w = q[ch].pop_front();
                        check("drain_order", int'(outs[ch]), w);
                    end
                end
            end
        end
        if (r) begin
            for (int ch = 0; ch < 4; ch++) begin
                q[ch].delete();
                m_valid[ch] = 0;
                m_data[ch]  = 0;
            end
            m_ptr = 0;
        end else begin
            for (int ch = 0; ch < 4; ch++) begin
                if (m_valid[ch] && rd[ch]) m_valid[ch] = 0;
            end
            if (acc) begin
                q[sel].push_back(din);
                m_valid[sel] = 1;
                m_data[sel]  = din;
                if (m) m_ptr = (m_ptr + 1) % 4;
            end
        end
        @(posedge clk);
        #1;
        for (int ch = 0; ch < 4; ch++) begin
            check("valid", int'(vals[ch]), int'(m_valid[ch]));
            check("out", int'(outs[ch]), m_data[ch]);
        end
        check("ptr", int'(Ptr), m_ptr);
    endtask

    initial begin
        rst = 1'b1; InValid = 1'b0; In = '0; S = '0; Mode = 1'b0;
        {ReadyD, ReadyC, ReadyB, ReadyA} = 4'h0;
        for (int ch = 0; ch < 4; ch++) begin
            m_data[ch] = 0;
            m_valid[ch] = 0;
        end
        m_ptr = 0;
        @(posedge clk);
        #1;

        // Reset mid-traffic
        cyc(0, 1, 9, 0, 1, 4'h0);
        cyc(0, 1, 6, 0, 1, 4'h0);
        cyc(1, 1, 4, 2, 1, 4'h0);
        cyc(1, 1, 4, 2, 1, 4'h0);
        check("rst_ptr", int'(Ptr), 0);
        check("rst_valid", int'(vals), 0);

        // Direct mode load into C
        cyc(0, 1, 4'hA, 2, 0, 4'hF);
        check("t2_outc", int'(OutC), 4'hA);
        check("t2_valc", int'(ValidC), 1);
        check("t2_others", int'({ValidD, ValidB, ValidA}), 0);

        // Backpressure on B, redirected to A the same cycle
        cyc(0, 1, 4'h3, 1, 0, 4'b1101);
        cyc(0, 1, 4'h5, 1, 0, 4'b1101);
        check("t3_outb", int'(OutB), 4'h3);
        cyc(0, 1, 4'h5, 0, 0, 4'b1101);
        check("t3_outa", int'(OutA), 4'h5);

        // Pass-through on D, one word per cycle
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 7 + i, 3, 0, 4'hF);
            check("t4_vald", int'(ValidD), 1);
            check("t4_outd", int'(OutD), 7 + i);
        end
        cyc(0, 0, 0, 0, 0, 4'hF);

        // Round-robin sequence and stall
        cyc(1, 0, 0, 0, 0, 4'h0);
        for (int i = 1; i <= 4; i++) cyc(0, 1, i, 3, 1, 4'h0);
        check("t5_abcd", int'({OutD, OutC, OutB, OutA}), 16'h4321);
        cyc(0, 1, 5, 3, 1, 4'h0);
        check("t5_stall_ptr", int'(Ptr), 0);
        cyc(0, 1, 5, 3, 1, 4'hF);
        check("t5_outa", int'(OutA), 5);
        check("t5_ptr", int'(Ptr), 1);

        // Random traffic
        for (int i = 0; i < 10000; i++) begin
            cyc(($urandom_range(0, 499) == 0), $urandom_range(0, 3) != 0,
                $urandom_range(0, 15), $urandom_range(0, 3),
                $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)));
        end

        // Every accepted word is either delivered or still held
        for (int ch = 0; ch < 4; ch++) begin
            check("residual", q[ch].size(), m_valid[ch] ? 1 : 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
